// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmitter.
// Holds the frame FSM state encoding and the parity-mode selectors.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PAR,
        STOP
    } state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_EVEN = 1;
    localparam int PAR_ODD  = 2;

endpackage

// File: rtl/uart_tx.sv
// LSB-first UART transmitter paced by a sampled divided clock (baud_i).
// One frame is start, D data bits, optional parity and STOP_N stop bits.
module uart_tx
    import uart_pkg::*;
#(
    parameter int D      = 8,
    parameter int PARITY = PAR_NONE,
    parameter int STOP_N = 1
) (
    input  logic         clk_i,
    input  logic         rst_n_i,
    input  logic         baud_i,
    input  logic [D-1:0] data_i,
    input  logic         valid_i,
    output logic         ready_o,
    output logic         tx_o,
    output logic         busy_o
);

    localparam int            CW        = $clog2(D + 1);
    localparam logic [CW-1:0] LAST_DATA = CW'(D - 1);
    localparam logic          STOP_LAST = (STOP_N == 2);

    state_t        state_q, state_d;
    logic          pending_q, pending_d;
    logic [D-1:0]  sr_q, sr_d;
    logic [CW-1:0] bit_cnt_q, bit_cnt_d;
    logic          stop_cnt_q, stop_cnt_d;
    logic          par_q, par_d;
    logic          tx_q, tx_d;
    logic          ready_q, ready_d;
    logic          baud_q;

    logic tick;
    logic xfer;

    assign tick = baud_i & ~baud_q;
    assign xfer = valid_i & ready_q;

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        sr_d       = sr_q;
        bit_cnt_d  = bit_cnt_q;
        stop_cnt_d = stop_cnt_q;
        par_d      = par_q;
        tx_d       = tx_q;

        // A byte accepted on a tick cycle stays pending until the following tick.
        if (xfer) begin
            sr_d      = data_i;
            pending_d = 1'b1;
        end

        if (tick) begin
            case (state_q)
                IDLE: begin
                    if (pending_q) begin
                        state_d   = START;
                        tx_d      = 1'b0;
                        pending_d = 1'b0;
                    end
                end
                START: begin
                    state_d   = DATA;
                    tx_d      = sr_q[0];
                    sr_d      = sr_q >> 1;
                    bit_cnt_d = '0;
                    par_d     = sr_q[0];
                end
                DATA: begin
                    if (bit_cnt_q == LAST_DATA) begin
                        stop_cnt_d = 1'b0;
                        if (PARITY != PAR_NONE) begin
                            state_d = PAR;
                            tx_d    = (PARITY == PAR_ODD) ? ~par_q : par_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + 1'b1;
                        tx_d      = sr_q[0];
                        sr_d      = sr_q >> 1;
                        par_d     = par_q ^ sr_q[0];
                    end
                end
                PAR: begin
                    state_d    = STOP;
                    tx_d       = 1'b1;
                    stop_cnt_d = 1'b0;
                end
                STOP: begin
                    if (stop_cnt_q == STOP_LAST) begin
                        if (pending_q) begin
                            state_d   = START;
                            tx_d      = 1'b0;
                            pending_d = 1'b0;
                        end else begin
                            state_d = IDLE;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        stop_cnt_d = 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    tx_d    = 1'b1;
                end
            endcase
        end

        // Accepting during the last stop bit lets the next frame follow with no gap.
        ready_d = ~pending_d &
                  ((state_d == IDLE) | ((state_d == STOP) & (stop_cnt_d == STOP_LAST)));
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q    <= IDLE;
            pending_q  <= 1'b0;
            sr_q       <= '0;
            bit_cnt_q  <= '0;
            stop_cnt_q <= 1'b0;
            par_q      <= 1'b0;
            tx_q       <= 1'b1;
            ready_q    <= 1'b1;
            baud_q     <= 1'b1;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            sr_q       <= sr_d;
            bit_cnt_q  <= bit_cnt_d;
            stop_cnt_q <= stop_cnt_d;
            par_q      <= par_d;
            tx_q       <= tx_d;
            ready_q    <= ready_d;
            baud_q     <= baud_i;
        end
    end

    assign tx_o    = tx_q;
    assign ready_o = ready_q;
    assign busy_o  = (state_q != IDLE) | pending_q;

endmodule
